// File: rtl/hazard_interlock_if.sv
// Hazard interlock bundle: ID/EX/MEM hazard sources in, pipeline-register controls out.
// The master drives hazard sources; the slave (interlock) drives the controls.
interface hazard_interlock_if;
    logic [4:0] rAID;
    logic [4:0] rBID;
    logic       rAValidID;
    logic       rBValidID;
    logic [4:0] rWEX;
    logic       rW_enEX;
    logic       memReadEX;
    logic       branchTakenEX;
    logic       memReqMEM;
    logic       memRdyMEM;
    logic       stallIF;
    logic       stallID;
    logic       stallEX;
    logic       stallMEM;
    logic       flushID;
    logic       flushEX;
    logic       bubbleWB;

    modport master (
        output rAID, rBID, rAValidID, rBValidID,
        output rWEX, rW_enEX, memReadEX, branchTakenEX,
        output memReqMEM, memRdyMEM,
        input  stallIF, stallID, stallEX, stallMEM,
        input  flushID, flushEX, bubbleWB
    );

    modport slave (
        input  rAID, rBID, rAValidID, rBValidID,
        input  rWEX, rW_enEX, memReadEX, branchTakenEX,
        input  memReqMEM, memRdyMEM,
        output stallIF, stallID, stallEX, stallMEM,
        output flushID, flushEX, bubbleWB
    );
endinterface

// File: rtl/hazard_interlock.sv
// Pipeline hazard interlock: memory wait > taken branch > load-use priority.
// Optional macro HAZARD_STAT_EN builds saturating stall/flush statistics counters.
module hazard_interlock (
    input  logic                     clk,
    input  logic                     rst_n,
    hazard_interlock_if.slave        bus,
    output logic [1:0]               state,
    output logic                     memTimeout,
    output logic [15:0]              stallCnt,
    output logic [15:0]              flushCnt
);

    typedef enum logic [1:0] {
        RUN = 2'd0,
        LU  = 2'd1,
        MW  = 2'd2,
        FL  = 2'd3
    } state_t;

    state_t     cur;
    state_t     nxt;
    logic [7:0] wait_cnt;
    logic       mem_wait;
    logic       hit_a;
    logic       hit_b;
    logic       load_use;

    // Hazard detection; register 0 is hardwired and never creates a dependency.
    always_comb begin
        mem_wait = bus.memReqMEM & ~bus.memRdyMEM;
        hit_a    = (bus.rWEX == bus.rAID) & bus.rAValidID;
        hit_b    = (bus.rWEX == bus.rBID) & bus.rBValidID;
        load_use = bus.memReadEX & bus.rW_enEX & (bus.rWEX != 5'd0) & (hit_a | hit_b);
    end

    // Prioritised controls and next state; controls forced low while in reset.
    always_comb begin
        bus.stallIF  = 1'b0;
        bus.stallID  = 1'b0;
        bus.stallEX  = 1'b0;
        bus.stallMEM = 1'b0;
        bus.flushID  = 1'b0;
        bus.flushEX  = 1'b0;
        bus.bubbleWB = 1'b0;
        nxt          = RUN;
        if (mem_wait) begin
            nxt = MW;
            if (rst_n) begin
                bus.stallIF  = 1'b1;
                bus.stallID  = 1'b1;
                bus.stallEX  = 1'b1;
                bus.stallMEM = 1'b1;
                bus.bubbleWB = 1'b1;
            end
        end else if (bus.branchTakenEX) begin
            nxt = FL;
            if (rst_n) begin
                bus.flushID = 1'b1;
                bus.flushEX = 1'b1;
            end
        end else if (load_use) begin
            nxt = LU;
            if (rst_n) begin
                bus.stallIF = 1'b1;
                bus.stallID = 1'b1;
                bus.flushEX = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= RUN;
        end else begin
            cur <= nxt;
        end
    end

    assign state = cur;

    // Memory-wait watchdog; the flag is sticky until reset, the stall itself continues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt   <= 8'd0;
            memTimeout <= 1'b0;
        end else if (!mem_wait) begin
            wait_cnt <= 8'd0;
        end else if (cur == MW) begin
            if (wait_cnt != 8'hFF) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (wait_cnt >= 8'd254) begin
                memTimeout <= 1'b1;
            end
        end
    end

`ifdef HAZARD_STAT_EN
    // Saturating statistics: stall cycles (memory wait or load-use) and flush cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt <= 16'd0;
            flushCnt <= 16'd0;
        end else begin
            if (bus.stallIF && stallCnt != 16'hFFFF) begin
                stallCnt <= stallCnt + 16'd1;
            end
            if (bus.flushID && flushCnt != 16'hFFFF) begin
                flushCnt <= flushCnt + 16'd1;
            end
        end
    end
`else
    assign stallCnt = 16'd0;
    assign flushCnt = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_interlock.sv
// Testbench for hazard_interlock: directed vectors, queued expectations,
// monitor compares controls, state, watchdog and counters each cycle.
module tb_hazard_interlock;

    logic        clk;
    logic        rst_n;
    logic [1:0]  state;
    logic        memTimeout;
    logic [15:0] stallCnt;
    logic [15:0] flushCnt;

    hazard_interlock_if hif ();

    hazard_interlock dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (hif),
        .state      (state),
        .memTimeout (memTimeout),
        .stallCnt   (stallCnt),
        .flushCnt   (flushCnt)
    );

    // {stallIF,stallID,stallEX,stallMEM,flushID,flushEX,bubbleWB}
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_MW   = 7'b1111001;
    localparam logic [6:0] C_BR   = 7'b0000110;
    localparam logic [6:0] C_LU   = 7'b1100010;

    localparam logic [1:0] S_RUN = 2'd0;
    localparam logic [1:0] S_LU  = 2'd1;
    localparam logic [1:0] S_MW  = 2'd2;
    localparam logic [1:0] S_FL  = 2'd3;

    typedef struct {
        string      nm;
        logic       rst;
        logic [6:0] ec;
        logic [1:0] es;
        logic       eto;
    } exp_t;

    exp_t q[$];
    int   total  = 0;
    int   passed = 0;
    int   acc_s  = 0;
    int   acc_f  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input string what,
                         input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s %s got %h want %h", nm, what, act, exp);
        end else begin
            passed++;
        end
    endtask

    // Apply one cycle of stimulus just after the rising edge and queue its expectation.
    task automatic vec(input string nm, input logic r,
                       input logic [4:0] ra, input logic [4:0] rb,
                       input logic av, input logic bv,
                       input logic [4:0] rw, input logic wen, input logic mrd,
                       input logic br, input logic req, input logic rdy,
                       input logic [6:0] ec, input logic [1:0] es, input logic eto);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n             = ~r;
        hif.rAID          = ra;
        hif.rBID          = rb;
        hif.rAValidID     = av;
        hif.rBValidID     = bv;
        hif.rWEX          = rw;
        hif.rW_enEX       = wen;
        hif.memReadEX     = mrd;
        hif.branchTakenEX = br;
        hif.memReqMEM     = req;
        hif.memRdyMEM     = rdy;
        e.nm  = nm;
        e.rst = r;
        e.ec  = ec;
        e.es  = es;
        e.eto = eto;
        q.push_back(e);
    endtask

    task automatic idle(input string nm, input logic [1:0] es, input logic eto);
        vec(nm, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, C_NONE, es, eto);
    endtask

    // Monitor: compare the DUT against the oldest queued expectation mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [6:0] act;
            int es_c;
            int ef_c;
            e   = q.pop_front();
            act = {hif.stallIF, hif.stallID, hif.stallEX, hif.stallMEM,
                   hif.flushID, hif.flushEX, hif.bubbleWB};
            es_c = e.rst ? 0 : acc_s;
            ef_c = e.rst ? 0 : acc_f;
`ifndef HAZARD_STAT_EN
            es_c = 0;
            ef_c = 0;
`endif
            check(e.nm, "ctrl", {9'd0, act}, {9'd0, e.ec});
            check(e.nm, "state", {14'd0, state}, {14'd0, e.es});
            check(e.nm, "memTimeout", {15'd0, memTimeout}, {15'd0, e.eto});
            check(e.nm, "stallCnt", stallCnt, es_c[15:0]);
            check(e.nm, "flushCnt", flushCnt, ef_c[15:0]);
            if (e.rst) begin
                acc_s = 0;
                acc_f = 0;
            end else begin
                acc_s = acc_s + int'(e.ec[6]);
                acc_f = acc_f + int'(e.ec[2]);
            end
        end
    end

    initial begin
        rst_n             = 1'b0;
        hif.rAID          = 5'd0;
        hif.rBID          = 5'd0;
        hif.rAValidID     = 1'b0;
        hif.rBValidID     = 1'b0;
        hif.rWEX          = 5'd0;
        hif.rW_enEX       = 1'b0;
        hif.memReadEX     = 1'b0;
        hif.branchTakenEX = 1'b0;
        hif.memReqMEM     = 1'b0;
        hif.memRdyMEM     = 1'b0;

        vec("rst_memwait", 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, 0, C_NONE, S_RUN, 0);
        vec("rst_loaduse", 1, 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 0, 0, 0, C_NONE, S_RUN, 0);
        idle("idle0", S_RUN, 0);
        vec("lu_a", 0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 0, 0, 0, C_LU, S_RUN, 0);
        idle("after_lu", S_LU, 0);
        vec("lu_reg0", 0, 5'd0, 5'd0, 1, 0, 5'd0, 1, 1, 0, 0, 0, C_NONE, S_RUN, 0);
        vec("lu_b", 0, 5'd3, 5'd7, 1, 1, 5'd7, 1, 1, 0, 0, 0, C_LU, S_RUN, 0);
        vec("lu_a_invalid", 0, 5'd9, 5'd0, 0, 0, 5'd9, 1, 1, 0, 0, 0, C_NONE, S_LU, 0);
        vec("lu_no_wen", 0, 5'd9, 5'd0, 1, 0, 5'd9, 0, 1, 0, 0, 0, C_NONE, S_RUN, 0);
        vec("lu_no_load", 0, 5'd9, 5'd0, 1, 0, 5'd9, 1, 0, 0, 0, 0, C_NONE, S_RUN, 0);
        vec("br_and_lu", 0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 1, 0, 0, C_BR, S_RUN, 0);
        idle("after_br", S_FL, 0);
        vec("mw_br_1", 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, 0, C_MW, S_RUN, 0);
        vec("mw_br_2", 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, 0, C_MW, S_MW, 0);
        vec("mw_br_3", 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, 0, C_MW, S_MW, 0);
        vec("mem_ready_lu", 0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 0, 1, 1, C_LU, S_MW, 0);
        idle("after_lu2", S_LU, 0);
        vec("mw_over_lu", 0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 0, 1, 0, C_MW, S_RUN, 0);
        vec("mw_hold", 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, C_MW, S_MW, 0);
        vec("rst_in_mw", 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, C_NONE, S_RUN, 0);
        vec("first_after_rst", 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, C_MW, S_RUN, 0);
        idle("idle1", S_MW, 0);

        for (int j = 1; j <= 256; j++) begin
            vec("watchdog", 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0,
                C_MW, (j == 1) ? S_RUN : S_MW, 0);
        end
        idle("timeout_set", S_MW, 1);
        idle("timeout_hold", S_RUN, 1);
        vec("timeout_lu", 0, 5'd4, 5'd0, 1, 0, 5'd4, 1, 1, 0, 0, 0, C_LU, S_RUN, 1);
        vec("timeout_rst", 1, 5'd4, 5'd0, 1, 0, 5'd4, 1, 1, 0, 0, 0, C_NONE, S_RUN, 0);
        idle("idle_end", S_RUN, 0);

        for (int k = 0; k < 10 && q.size() > 0; k++) begin
            @(posedge clk);
        end
        total++;
        if (q.size() != 0) begin
            $display("FAIL drain queue left %0d want 0", q.size());
        end else begin
            passed++;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
